sobel_window_streamer: RTL and testbench

- Front end for the Sobel convolver. It accepts a raster-order pixel stream through a valid/ready handshake.
- Two row line buffers plus a 3x3 shift register form every fully-interior 3x3 neighbourhood of an IMG_H x IMG_W frame.
- Each window is presented on a registered valid/ready output, one window per kernel position. This matches the (IMG_H-2) x (IMG_W-2) result grid the convolver produces.

---
 rtl/sobel_window_streamer_if.sv | 31 +++
 rtl/sobel_window_streamer.sv | 111 +++++++++++
 tb/tb_sobel_window_streamer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sobel_window_streamer_if.sv
// Pixel-in / window-out handshake bundle for sobel_window_streamer.
// slave is the streamer's view, master is the producer/consumer side.
interface sobel_window_streamer_if #(
  parameter int PIX_W = 11,
  parameter int IMG_W = 8,
  parameter int IMG_H = 7
);
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);

  logic             s_valid;
  logic             s_ready;
  logic [PIX_W-1:0] s_data;

  logic               m_valid;
  logic               m_ready;
  logic [9*PIX_W-1:0] m_win;
  logic [RW-1:0]      m_row;
  logic [CW-1:0]      m_col;
  logic               m_last;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_win, m_row, m_col, m_last
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_win, m_row, m_col, m_last
  );
endinterface

// File: rtl/sobel_window_streamer.sv
// Builds every interior 3x3 neighbourhood of a raster pixel stream using two
// line buffers and a shifting window register, one registered window per position.
module sobel_window_streamer #(
  parameter int PIX_W = 11,
  parameter int IMG_W = 8,
  parameter int IMG_H = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  sobel_window_streamer_if.slave  bus,
  output logic                    frame_done
);
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] R_TWO  = RW'(2);
  localparam logic [CW-1:0] C_TWO  = CW'(2);

  typedef logic [PIX_W-1:0] pix_t;

  pix_t lb0 [IMG_W];
  pix_t lb1 [IMG_W];
  pix_t win    [9];
  pix_t win_nx [9];

  logic [RW-1:0]      r;
  logic [CW-1:0]      c;
  logic               accept;
  logic               emit;
  logic               last_pix;
  logic [9*PIX_W-1:0] win_flat;

  logic               mv;
  logic [9*PIX_W-1:0] mwin;
  logic [RW-1:0]      mrow;
  logic [CW-1:0]      mcol;
  logic               mlast;

  assign bus.s_ready = !mv || bus.m_ready;
  assign bus.m_valid = mv;
  assign bus.m_win   = mwin;
  assign bus.m_row   = mrow;
  assign bus.m_col   = mcol;
  assign bus.m_last  = mlast;

  assign accept   = bus.s_valid && bus.s_ready;
  assign last_pix = (r == R_LAST) && (c == C_LAST);
  // Columns 0..1 and rows 0..1 only prime the buffers, so stale data never escapes.
  assign emit     = accept && (r >= R_TWO) && (c >= C_TWO);

  always_comb begin
    win_nx[0] = win[1];
    win_nx[1] = win[2];
    win_nx[2] = lb1[c];
    win_nx[3] = win[4];
    win_nx[4] = win[5];
    win_nx[5] = lb0[c];
    win_nx[6] = win[7];
    win_nx[7] = win[8];
    win_nx[8] = bus.s_data;
  end

  always_comb begin
    win_flat = '0;
    for (int unsigned k = 0; k < 9; k++) begin
      win_flat[k*PIX_W +: PIX_W] = win_nx[k];
    end
  end

  // Pixel storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[c] <= lb0[c];
      lb0[c] <= bus.s_data;
      win    <= win_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r          <= '0;
      c          <= '0;
      mv         <= 1'b0;
      mwin       <= '0;
      mrow       <= '0;
      mcol       <= '0;
      mlast      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept && last_pix;
      if (accept) begin
        if (c == C_LAST) begin
          c <= '0;
          r <= (r == R_LAST) ? '0 : r + 1'b1;
        end else begin
          c <= c + 1'b1;
        end
      end
      if (emit) begin
        mv    <= 1'b1;
        mwin  <= win_flat;
        mrow  <= r - R_TWO;
        mcol  <= c - C_TWO;
        mlast <= last_pix;
      end else if (bus.m_ready) begin
        mv <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sobel_window_streamer.sv
// Randomized bench for sobel_window_streamer against a whole-frame image model.
module tb_sobel_window_streamer;
  localparam int PIX_W = 11;
  localparam int IMG_W = 8;
  localparam int IMG_H = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_done;

  always #5 clk = ~clk;

  sobel_window_streamer_if #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) bus ();

  sobel_window_streamer #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .frame_done (frame_done)
  );

  typedef struct {
    int                 row;
    int                 col;
    logic [9*PIX_W-1:0] win;
    bit                 last;
  } win_t;

  int   img [IMG_H][IMG_W];
  win_t q [$];
  int   pr, pc;
  bit   exp_mv, exp_fd;

  int n_checks = 0;
  int n_fail   = 0;

  int nwin, nlast, nfd, naccept, px_left;
  int vprob, ready_mode, pmode;
  bit saw_mv, chk_latency;
  logic [9*PIX_W-1:0] first_w, last_w;
  int first_row, first_col, last_row, last_col;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [9*PIX_W-1:0] mkwin(input int r0, input int c0);
    logic [9*PIX_W-1:0] w = '0;
    for (int k = 0; k < 3; k++)
      for (int l = 0; l < 3; l++)
        w[(3*k+l)*PIX_W +: PIX_W] = PIX_W'(img[r0+k][c0+l]);
    return w;
  endfunction

  function automatic logic [9*PIX_W-1:0] pack9(input int v [9]);
    logic [9*PIX_W-1:0] w = '0;
    for (int k = 0; k < 9; k++) w[k*PIX_W +: PIX_W] = PIX_W'(v[k]);
    return w;
  endfunction

  function automatic int pix_val(input int r, input int c);
    case (pmode)
      0:       return 16*r + c;
      1:       return (r == 3 && c == 4) ? 0 : 2047;
      default: return int'($urandom_range(2047));
    endcase
  endfunction

  task automatic clear_stats();
    nwin = 0; nlast = 0; nfd = 0; naccept = 0; saw_mv = 0;
  endtask

  // One clock: drive after the edge, check and advance the model on the falling edge.
  task automatic step();
    bit exp_sr, acc, newwin, next_fd;
    win_t w;
    bus.s_valid = (px_left > 0) && (int'($urandom_range(99)) < vprob);
    bus.s_data  = PIX_W'(pix_val(pr, pc));
    case (ready_mode)
      0:       bus.m_ready = 1'b0;
      1:       bus.m_ready = 1'b1;
      default: bus.m_ready = 1'($urandom_range(1));
    endcase
    @(negedge clk);
    exp_sr = !exp_mv || bus.m_ready;
    check("m_valid", bus.m_valid, exp_mv);
    check("s_ready", bus.s_ready, exp_sr);
    check("frame_done", frame_done, exp_fd);
    if (frame_done) nfd++;
    if (bus.m_valid && !saw_mv) begin
      saw_mv = 1;
      if (chk_latency) check("first_mv_accepts", naccept, 19);
    end
    if (exp_mv && q.size() != 0) begin
      check("m_row", bus.m_row, q[0].row);
      check("m_col", bus.m_col, q[0].col);
      check("m_win", bus.m_win, q[0].win);
      check("m_last", bus.m_last, q[0].last);
    end
    newwin = 0;
    next_fd = 0;
    acc = bus.s_valid && exp_sr;
    if (exp_mv && bus.m_ready) begin
      w = q.pop_front();
      if (nwin == 0) begin
        first_w = bus.m_win; first_row = bus.m_row; first_col = bus.m_col;
      end
      if (bus.m_last) begin
        nlast++; last_w = bus.m_win; last_row = bus.m_row; last_col = bus.m_col;
      end
      nwin++;
    end
    if (acc) begin
      img[pr][pc] = int'(bus.s_data);
      naccept++;
      px_left--;
      if (pr >= 2 && pc >= 2) begin
        w.row = pr - 2; w.col = pc - 2; w.win = mkwin(pr - 2, pc - 2);
        w.last = (pr == IMG_H-1 && pc == IMG_W-1);
        q.push_back(w);
        newwin = 1;
      end
      if (pr == IMG_H-1 && pc == IMG_W-1) next_fd = 1;
      pc++;
      if (pc == IMG_W) begin
        pc = 0; pr++;
        if (pr == IMG_H) pr = 0;
      end
    end
    exp_mv = newwin || (exp_mv && !bus.m_ready);
    exp_fd = next_fd;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    exp_mv = 0; exp_fd = 0; pr = 0; pc = 0; px_left = 0;
  endtask

  task automatic run_windows(input int target, input int budget);
    int cyc = 0;
    while (nwin < target && cyc < budget) begin
      step();
      cyc++;
    end
    check("window_timeout", nwin >= target, 1);
    repeat (3) step();
  endtask

  initial begin
    int fa [9];
    int la [9];
    logic [9*PIX_W-1:0] held_w;
    int held_r, held_c, cyc;

    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    vprob = 100; ready_mode = 1; pmode = 0; chk_latency = 0; px_left = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    exp_mv = 0; exp_fd = 0; pr = 0; pc = 0;
    @(negedge clk);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_win", bus.m_win, 0);
    check("rst_m_row", bus.m_row, 0);
    check("rst_m_col", bus.m_col, 0);
    check("rst_m_last", bus.m_last, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_s_ready", bus.s_ready, 1);
    @(posedge clk);
    #1;

    // Continuous ramp frame
    clear_stats();
    chk_latency = 1; pmode = 0; vprob = 100; ready_mode = 1; px_left = IMG_H*IMG_W;
    run_windows(30, 200);
    chk_latency = 0;
    fa = '{0, 1, 2, 16, 17, 18, 32, 33, 34};
    la = '{69, 70, 71, 85, 86, 87, 101, 102, 103};
    check("ramp_count", nwin, 30);
    check("ramp_first_win", first_w, pack9(fa));
    check("ramp_first_pos", {first_row, first_col}, {32'd0, 32'd0});
    check("ramp_last_win", last_w, pack9(la));
    check("ramp_last_pos", {last_row, last_col}, {32'd4, 32'd5});
    check("ramp_nlast", nlast, 1);
    check("ramp_frame_done", nfd, 1);

    // Backpressure after the first window
    clear_stats();
    ready_mode = 1; px_left = IMG_H*IMG_W;
    cyc = 0;
    while (!saw_mv && cyc < 100) begin step(); cyc++; end
    check("bp_first_timeout", saw_mv, 1);
    ready_mode = 0;
    step();
    held_w = bus.m_win; held_r = bus.m_row; held_c = bus.m_col;
    repeat (10) step();
    check("bp_hold_win", bus.m_win, held_w);
    check("bp_hold_pos", {bus.m_row, bus.m_col}, {held_r[2:0], held_c[2:0]});
    check("bp_s_ready", bus.s_ready, 0);
    ready_mode = 1;
    run_windows(30, 300);
    check("bp_count", nwin, 30);
    check("bp_frame_done", nfd, 1);

    // Three back-to-back random frames with random gaps and stalls
    clear_stats();
    pmode = 2; vprob = 50; ready_mode = 2; px_left = 3*IMG_H*IMG_W;
    run_windows(90, 5000);
    check("rand_count", nwin, 90);
    check("rand_nlast", nlast, 3);
    check("rand_frame_done", nfd, 3);

    // Full-scale frame with a single zero pixel
    clear_stats();
    pmode = 1; vprob = 100; ready_mode = 2; px_left = IMG_H*IMG_W;
    run_windows(30, 1000);
    check("ext_count", nwin, 30);

    // Reset mid-frame with a window pending
    clear_stats();
    pmode = 0; vprob = 100; ready_mode = 1; px_left = 20;
    cyc = 0;
    while (naccept < 20 && cyc < 100) begin step(); cyc++; end
    check("mid_accepts", naccept, 20);
    ready_mode = 0;
    step();
    check("mid_pending", bus.m_valid, 1);
    do_reset();
    clear_stats();
    step();
    pmode = 2; vprob = 80; ready_mode = 2; px_left = IMG_H*IMG_W;
    run_windows(30, 1000);
    check("post_rst_count", nwin, 30);
    check("post_rst_first_pos", {first_row, first_col}, {32'd0, 32'd0});
    check("post_rst_frame_done", nfd, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
